// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES round-subkey generator, encrypt (K1..K16) or decrypt (K16..K1) order
// FIPS bit n (1 = MSB) of an N-bit vector sits at index N-n.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  subkey_num,
  output logic [3:0]  round_num,
  output logic        last
);
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  typedef enum logic {IDLE, GEN} state_t;
  state_t      state, state_nx;
  logic [27:0] c, d, c_nx, d_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        mode, mode_nx, one, gen;
  logic [55:0] cd_key, cd;
  logic [47:0] pc2_out;
  logic        unused_parity;
  function automatic logic [27:0] rot(input logic [27:0] x, input logic right, input logic by1);
    rot = right ? (by1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]})
                : (by1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]});
  endfunction
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0]};
  assign cd = {c, d};
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign cd_key[55-i] = key_in[64-PC1[i]];
  end
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign pc2_out[47-i] = cd[56-PC2[i]];
  end
  // Single-bit shifts fall on the same counter values for both directions
  assign one = (cnt == 4'd0) || (cnt == 4'd7) || (cnt == 4'd14);
  assign gen = (state == GEN);
  always_comb begin
    state_nx = state;
    c_nx     = c;
    d_nx     = d;
    cnt_nx   = cnt;
    mode_nx  = mode;
    if (!gen && key_valid) begin
      state_nx = GEN;
      mode_nx  = decrypt;
      cnt_nx   = 4'd0;
      c_nx     = decrypt ? cd_key[55:28] : rot(cd_key[55:28], 1'b0, 1'b1);
      d_nx     = decrypt ? cd_key[27:0]  : rot(cd_key[27:0],  1'b0, 1'b1);
    end else if (gen && subkey_ready) begin
      state_nx = (cnt == 4'd15) ? IDLE : GEN;
      cnt_nx   = (cnt == 4'd15) ? cnt : cnt + 4'd1;
      c_nx     = (cnt == 4'd15) ? c : rot(c, mode, one);
      d_nx     = (cnt == 4'd15) ? d : rot(d, mode, one);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_nx;
      c     <= c_nx;
      d     <= d_nx;
      cnt   <= cnt_nx;
      mode  <= mode_nx;
    end
  end
  assign key_ready    = !gen;
  assign subkey_valid = gen;
  assign subkey       = gen ? pc2_out : '0;
  assign round_num    = gen ? cnt : 4'd0;
  assign subkey_num   = gen ? (mode ? 4'd15 - cnt : cnt) : 4'd0;
  assign last         = gen && (cnt == 4'd15);
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: directed and random key runs against a table-driven DES key-schedule model
module tb_des_key_schedule;
  logic        clk = 1'b0, rst = 1'b1, key_valid = 1'b0, decrypt = 1'b0, subkey_ready = 1'b0;
  logic [63:0] key_in = '0;
  logic        key_ready, subkey_valid, last;
  logic [47:0] subkey;
  logic [3:0]  subkey_num, round_num;
  int errors = 0, checks = 0;
  logic [47:0] ref_ks [16];
  localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int T_SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  des_key_schedule dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .decrypt(decrypt), .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready), .subkey(subkey), .subkey_num(subkey_num),
    .round_num(round_num), .last(last));
  always #5 clk = ~clk;
  function automatic void gen_ref(input logic [63:0] k);
    logic [63:0] c, d, cdv, sk;
    c = 0;
    d = 0;
    for (int i = 0; i < 28; i++) c = (c << 1) | ((k >> (64 - T_PC1[i])) & 64'd1);
    for (int i = 28; i < 56; i++) d = (d << 1) | ((k >> (64 - T_PC1[i])) & 64'd1);
    for (int r = 0; r < 16; r++) begin
      c = ((c << T_SH[r]) | (c >> (28 - T_SH[r]))) & 64'hFFFFFFF;
      d = ((d << T_SH[r]) | (d >> (28 - T_SH[r]))) & 64'hFFFFFFF;
      cdv = (c << 28) | d;
      sk = 0;
      for (int i = 0; i < 48; i++) sk = (sk << 1) | ((cdv >> (56 - T_PC2[i])) & 64'd1);
      ref_ks[r] = sk[47:0];
    end
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  // mode 0: ready held high; 1: random ready with 10-cycle stall at round 8;
  // 2: stray key_valid during GEN; 3: async reset after 5th transfer
  task automatic run(input logic [63:0] k, input logic dec, input int mode);
    int n, cyc, st;
    @(negedge clk);
    chk("idle_key_ready", {63'd0, key_ready}, 64'd1);
    key_in = k;
    decrypt = dec;
    key_valid = 1'b1;
    subkey_ready = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    key_in = {$urandom, $urandom};
    decrypt = ~dec;
    n = 0;
    cyc = 0;
    st = 0;
    while (n < 16 && cyc < 300) begin
      if (mode == 3 && n == 5) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_subkey_valid", {63'd0, subkey_valid}, 64'd0);
        chk("rst_key_ready", {63'd0, key_ready}, 64'd1);
        chk("rst_subkey", {16'd0, subkey}, 64'd0);
        chk("rst_subkey_num", {60'd0, subkey_num}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (mode == 1 && n == 8 && st < 10) begin
        subkey_ready = 1'b0;
        st++;
      end else subkey_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 2) begin
        key_valid = (cyc >= 2 && cyc <= 4);
        key_in = 64'hFFFFFFFFFFFFFFFF;
      end
      chk("subkey_valid", {63'd0, subkey_valid}, 64'd1);
      chk("busy_key_ready", {63'd0, key_ready}, 64'd0);
      chk("subkey", {16'd0, subkey}, {16'd0, dec ? ref_ks[15-n] : ref_ks[n]});
      chk("subkey_num", {60'd0, subkey_num}, dec ? 64'(15 - n) : 64'(n));
      chk("round_num", {60'd0, round_num}, 64'(n));
      chk("last", {63'd0, last}, (n == 15) ? 64'd1 : 64'd0);
      if (k == KEY && n == 0) chk("kat_first", {16'd0, subkey}, dec ? 64'hCB3D8B0E17F5 : 64'h1B02EFFC7072);
      if (k == KEY && n == 15) chk("kat_last", {16'd0, subkey}, dec ? 64'h1B02EFFC7072 : 64'hCB3D8B0E17F5);
      if (subkey_ready) n++;
      @(negedge clk);
      cyc++;
    end
    key_valid = 1'b0;
    subkey_ready = 1'b0;
    chk("transfers", 64'(n), 64'd16);
    chk("done_key_ready", {63'd0, key_ready}, 64'd1);
    chk("done_subkey_valid", {63'd0, subkey_valid}, 64'd0);
  endtask
  initial begin
    logic [63:0] k;
    #1;
    chk("reset_key_ready", {63'd0, key_ready}, 64'd1);
    chk("reset_subkey_valid", {63'd0, subkey_valid}, 64'd0);
    chk("reset_subkey", {16'd0, subkey}, 64'd0);
    chk("reset_subkey_num", {60'd0, subkey_num}, 64'd0);
    chk("reset_round_num", {60'd0, round_num}, 64'd0);
    chk("reset_last", {63'd0, last}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gen_ref(KEY);
    run(KEY, 1'b0, 0);
    run(KEY, 1'b1, 0);
    run(KEY, 1'b0, 1);
    run(KEY, 1'b1, 1);
    run(KEY, 1'b0, 2);
    run(KEY ^ 64'h0101010101010101, 1'b0, 0);
    run(KEY ^ 64'h0101010101010101, 1'b1, 0);
    run(KEY, 1'b0, 3);
    run(KEY, 1'b0, 0);
    for (int t = 0; t < 6; t++) begin
      k = {$urandom, $urandom};
      gen_ref(k);
      run(k, 1'($urandom_range(0, 1)), $urandom_range(0, 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
